axi_lite_cfg_master: RTL
========================

AXI_LITE_CFG_MASTER -- requirements
Module: axi_lite_cfg_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: AXI-Lite data width.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 16: AXI-Lite and command address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit in clk cycles; 0 disables the watchdog.
REQ-004 SHALL have port clk, input, 1: the only clock; every output and register is synchronous to it.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port cmd_valid, input, 1: a command is presented.
REQ-007 SHALL have port cmd_ready, output, 1: the block accepts a command this cycle.
REQ-008 SHALL have port cmd_write, input, 1: 1 selects write, 0 selects read.
REQ-009 SHALL have port cmd_addr, input, C_M_AXI_ADDR_WIDTH: target byte address.
REQ-010 SHALL have port cmd_wdata, input, C_M_AXI_DATA_WIDTH: write data.
REQ-011 SHALL have port rsp_valid, output, 1: one-cycle pulse marking transaction completion.
REQ-012 SHALL have port rsp_rdata, output, C_M_AXI_DATA_WIDTH: read data of the last completed read.
REQ-013 SHALL have port rsp_resp, output, 2: BRESP or RRESP of the last transaction.
REQ-014 SHALL have port rsp_timeout, output, 1: the last transaction was ended by the watchdog.
REQ-015 SHALL have ports M_AXI_AWADDR (output, ADDR_WIDTH), M_AXI_AWVALID (output, 1) and M_AXI_AWREADY (input, 1): write address channel.
REQ-016 SHALL have ports M_AXI_WDATA (output, DATA_WIDTH), M_AXI_WSTRB (output, DATA_WIDTH/8), M_AXI_WVALID (output, 1) and M_AXI_WREADY (input, 1): write data channel.
REQ-017 SHALL have ports M_AXI_BRESP (input, 2), M_AXI_BVALID (input, 1) and M_AXI_BREADY (output, 1): write response channel.
REQ-018 SHALL have ports M_AXI_ARADDR (output, ADDR_WIDTH), M_AXI_ARVALID (output, 1) and M_AXI_ARREADY (input, 1): read address channel.
REQ-019 SHALL have ports M_AXI_RDATA (input, DATA_WIDTH), M_AXI_RRESP (input, 2), M_AXI_RVALID (input, 1) and M_AXI_RREADY (output, 1): read data channel.

Function
REQ-020 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ and RD_RESP, allowing at most one outstanding transaction.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready it SHALL latch cmd_addr/cmd_wdata and go to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0).
REQ-022 SHALL drive all AXI VALID/READY outputs from registers, asserted from the first cycle of the new state, with ADDR/WDATA held stable while VALID is high.
REQ-023 In WR_REQ it SHALL drive AWVALID and WVALID together and drop each one independently after its own READY is sampled; it SHALL go to WR_RESP once both handshakes are done, including when both occur in the same cycle.
REQ-024 SHALL drive BREADY=1 only in WR_RESP; on BVALID it SHALL capture BRESP and return to IDLE.
REQ-025 In RD_REQ it SHALL hold ARVALID until ARREADY and then go to RD_RESP.
REQ-026 SHALL drive RREADY=1 only in RD_RESP; on RVALID it SHALL capture RDATA/RRESP and return to IDLE.
REQ-027 SHALL pulse rsp_valid for exactly one cycle, on the cycle after the B or R handshake (the same cycle cmd_ready rises), and SHALL hold rsp_rdata/rsp_resp/rsp_timeout until the next completion; a write SHALL leave rsp_rdata unchanged.
REQ-028 SHALL tolerate a responder that asserts B/RVALID in the same cycle as its A/WREADY or ARREADY, or earlier; the response SHALL be accepted only in the RESP state.
REQ-029 SHALL drive M_AXI_WSTRB all-ones and pass the address through unmodified.
REQ-030 SHALL clear the watchdog counter on command acceptance and increment it every non-IDLE cycle.
REQ-031 On reaching TIMEOUT_CYCLES the watchdog SHALL deassert all VALID/READY, pulse rsp_valid with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0, and go to IDLE; a completion in the expiry cycle SHALL take priority.

Reset
REQ-032 While rst is sampled high on clk the block SHALL enter IDLE with all AXI VALID/READY, rsp_* outputs, latched address/data and counter at 0, and cmd_ready=1 from the first cycle after rst falls; a reset mid-transaction SHALL abandon it without a rsp_valid pulse.

Structure
REQ-033 The state enum, the response codes (OKAY=2'b00, SLVERR=2'b10) and the default TIMEOUT_CYCLES SHALL live in shared package axi_lite_pkg.
REQ-034 The watchdog SHALL be sub-module axi_timeout_ctr (inputs clear/enable, output expired); all other logic SHALL be flat.

Verification
REQ-035 Write addr 0x0004, data 0xA5A5_0001, zero-wait responder with BRESP=00 -> AW/W valid in cycle 1, rsp_valid in cycle 3, rsp_resp=00, rsp_timeout=0.
REQ-036 Write with WREADY delayed 5 cycles after AWREADY -> AWVALID drops after its handshake, WVALID stays high, and exactly one W beat and one B handshake occur.
REQ-037 Read addr 0x0000 from a responder asserting RVALID with ARREADY, RDATA=0x0000_0031 -> rsp_rdata=0x0000_0031, rsp_resp=00, then cmd_ready=1.
REQ-038 TIMEOUT_CYCLES=16 and a responder that never asserts BVALID -> rsp_valid 16 cycles after acceptance with rsp_timeout=1, rsp_resp=10, and all VALID/READY at 0.
REQ-039 rst pulsed while in RD_REQ with ARVALID=1 -> ARVALID=0 the next cycle, no rsp_valid, and a new command is accepted after rst falls.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI-Lite configuration master: FSM state
// encoding, AXI response codes and the default watchdog limit.
// ---------------------------------------------------------------------------
package axi_lite_pkg;

  // Master FSM states; at most one transaction is ever in flight
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axi_timeout_ctr.sv
// ---------------------------------------------------------------------------
// axi_timeout_ctr
// Watchdog counter for one outstanding AXI-Lite transaction.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - restart counting (command accepted)
//   enable    - count this cycle (transaction in flight)
//   expired   - the in-flight transaction must be abandoned this cycle
// LIMIT = 0 disables the watchdog (expired never asserts).
// ---------------------------------------------------------------------------
module axi_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  // The first busy cycle sees count 0 and the return to IDLE costs one
  // more edge, so firing at LIMIT-2 makes the timeout pulse land exactly
  // LIMIT cycles after the command was accepted.
  localparam logic [CW-1:0] EXPIRE_AT = (LIMIT >= 2) ? CW'(LIMIT - 2) : '0;

  logic [CW-1:0] count;

  // Count busy cycles; park at the expiry value so the counter never wraps
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != EXPIRE_AT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (LIMIT != 0) && enable && (count == EXPIRE_AT);

endmodule

// File: rtl/axi_lite_cfg_master.sv
// ---------------------------------------------------------------------------
// axi_lite_cfg_master
// Turns single read/write commands into AXI-Lite transactions, one at a time,
// with a watchdog that abandons a transaction the slave never finishes.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   cmd_*             - command handshake (valid/ready), write select,
//                       byte address and write data
//   rsp_*             - completion pulse, read data, BRESP/RRESP and
//                       watchdog flag of the last transaction
//   M_AXI_*           - AXI-Lite master channels AW, W, B, AR, R
// ---------------------------------------------------------------------------
module axi_lite_cfg_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  output logic                              rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  state_t                          state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                            accept;
  logic                            completion;
  logic                            expired;
  logic                            watchdog_fire;
  logic                            aw_done;
  logic                            w_done;

  assign cmd_ready    = (state == IDLE);
  assign accept       = cmd_valid && cmd_ready;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = '1;

  // A channel counts as done if it already dropped VALID or handshakes now
  assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

  // A B/R handshake in the expiry cycle wins over the watchdog
  assign completion    = ((state == WR_RESP) && M_AXI_BVALID) ||
                         ((state == RD_RESP) && M_AXI_RVALID);
  assign watchdog_fire = expired && !completion;

  axi_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (state != IDLE),
    .expired (expired)
  );

  // Transaction FSM; every AXI VALID/READY and rsp_* output is a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      rsp_timeout   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (watchdog_fire) begin
        state         <= IDLE;
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_timeout   <= 1'b1;
        rsp_resp      <= RESP_SLVERR;
        rsp_rdata     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              addr_q  <= cmd_addr;
              wdata_q <= cmd_wdata;
              if (cmd_write) begin
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                state         <= WR_REQ;
              end else begin
                M_AXI_ARVALID <= 1'b1;
                state         <= RD_REQ;
              end
            end
          end
          WR_REQ: begin
            if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
            if (aw_done && w_done) begin
              M_AXI_BREADY <= 1'b1;
              state        <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (M_AXI_BVALID) begin
              M_AXI_BREADY <= 1'b0;
              rsp_valid    <= 1'b1;
              rsp_resp     <= M_AXI_BRESP;
              rsp_timeout  <= 1'b0;
              state        <= IDLE;
            end
          end
          RD_REQ: begin
            if (M_AXI_ARREADY) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
              state         <= RD_RESP;
            end
          end
          RD_RESP: begin
            if (M_AXI_RVALID) begin
              M_AXI_RREADY <= 1'b0;
              rsp_valid    <= 1'b1;
              rsp_rdata    <= M_AXI_RDATA;
              rsp_resp     <= M_AXI_RRESP;
              rsp_timeout  <= 1'b0;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
